// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: PLLVR reset/lock supervisor with dynamic divider profile switching
module pll_reconfig_ctrl #(
    parameter int          NUM_PROFILES    = 4,
    parameter logic [47:0] PROF_IDSEL      = 48'h0,
    parameter logic [47:0] PROF_FBDSEL     = 48'h0,
    parameter logic [47:0] PROF_ODSEL      = 48'h0,
    parameter int          DEFAULT_PROFILE = 0,
    parameter int          RESET_HOLD      = 16,
    parameter int          LOCK_TIMEOUT    = 65535,
    parameter int          STABLE_CYCLES   = 1024,
    parameter int          RETRY_MAX       = 3
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       req,
    input  logic [2:0] req_profile,
    output logic       req_ack,
    output logic       req_err,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] idsel,
    output logic [5:0] fbdsel,
    output logic [5:0] odsel,
    output logic       locked,
    output logic       clk_rstn,
    output logic       busy,
    output logic       fault,
    output logic [2:0] active_profile,
    output logic [1:0] retry_cnt
);
    localparam int MAX_HL = (RESET_HOLD > LOCK_TIMEOUT) ? RESET_HOLD : LOCK_TIMEOUT;
    localparam int MAXC   = (MAX_HL > STABLE_CYCLES) ? MAX_HL : STABLE_CYCLES;
    localparam int CW     = $clog2(MAXC) + 1;
    localparam int RW0    = $clog2(RETRY_MAX + 2);
    localparam int RW     = (RW0 < 2) ? 2 : RW0;
    localparam logic [CW-1:0] HOLD_END = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] WAIT_END = CW'(LOCK_TIMEOUT - 1);
    // The cycle that moves WAIT into STABLE already saw lock_s=1, so it is the first stable cycle
    localparam logic [CW-1:0] STB_END  = CW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
    localparam logic [2:0]    DEF_P    = 3'(DEFAULT_PROFILE);

    typedef enum logic [2:0] {S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAULT} state_t;

    function automatic logic [5:0] tab_sel(input logic [47:0] tab, input logic [2:0] p);
        return 6'(tab >> (6 * int'(p)));
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [2:0]    prof_q, prof_d;
    logic [5:0]    idsel_q, fbdsel_q, odsel_q;
    logic [1:0]    rsync_q, lsync_q;
    logic          req_ack_q, req_ack_d, req_err_q, req_err_d;
    logic          pll_reset_q, locked_q, clk_rstn_q, busy_q, fault_q;
    logic          rst_n, lock_s, accept, load_div;

    assign rst_n    = rsync_q[1];
    assign lock_s   = lsync_q[1];
    assign accept   = req && (state_q == S_RUN || state_q == S_FAULT) && int'(req_profile) < NUM_PROFILES;
    assign load_div = state_d == S_HOLD && state_q != S_HOLD;

    // Reset asserts asynchronously and releases two clkin edges later
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) rsync_q <= 2'b00;
        else         rsync_q <= {rsync_q[0], 1'b1};
    end

    // Bring the asynchronous PLL lock into the clkin domain
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) lsync_q <= 2'b00;
        else        lsync_q <= {lsync_q[0], pll_lock};
    end

    // Sequencer next state; an accepted request overrides whatever the state would do
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        prof_d    = prof_q;
        req_ack_d = 1'b0;
        req_err_d = 1'b0;
        case (state_q)
            S_HOLD:   state_d = (cnt_q == HOLD_END) ? S_WAIT : S_HOLD;
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == WAIT_END) begin
                    retry_d = retry_q + RW'(1);
                    state_d = (int'(retry_d) > RETRY_MAX) ? S_FAULT : S_HOLD;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == STB_END) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_HOLD;
                    retry_d = '0;
                end
            end
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_HOLD;
        endcase
        if (req) begin
            req_ack_d = accept;
            req_err_d = !accept;
        end
        if (accept) begin
            prof_d  = req_profile;
            retry_d = '0;
            state_d = S_HOLD;
        end
        cnt_d = (state_d != state_q || state_q == S_RUN || state_q == S_FAULT) ? '0 : cnt_q + CW'(1);
    end

    // State, counters and status outputs are registered from the next state
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            prof_q      <= DEF_P;
            req_ack_q   <= 1'b0;
            req_err_q   <= 1'b0;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            clk_rstn_q  <= 1'b0;
            busy_q      <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            prof_q      <= prof_d;
            req_ack_q   <= req_ack_d;
            req_err_q   <= req_err_d;
            pll_reset_q <= state_d == S_HOLD || state_d == S_FAULT;
            locked_q    <= state_d == S_RUN;
            clk_rstn_q  <= state_d == S_RUN;
            busy_q      <= !(state_d == S_RUN || state_d == S_FAULT);
            fault_q     <= state_d == S_FAULT;
        end
    end

    // Dividers change only on entry to HOLD so they are settled before PLL reset releases
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            idsel_q  <= tab_sel(PROF_IDSEL, DEF_P);
            fbdsel_q <= tab_sel(PROF_FBDSEL, DEF_P);
            odsel_q  <= tab_sel(PROF_ODSEL, DEF_P);
        end else if (load_div) begin
            idsel_q  <= tab_sel(PROF_IDSEL, prof_d);
            fbdsel_q <= tab_sel(PROF_FBDSEL, prof_d);
            odsel_q  <= tab_sel(PROF_ODSEL, prof_d);
        end
    end

    assign req_ack        = req_ack_q;
    assign req_err        = req_err_q;
    assign pll_reset      = pll_reset_q;
    assign idsel          = idsel_q;
    assign fbdsel         = fbdsel_q;
    assign odsel          = odsel_q;
    assign locked         = locked_q;
    assign clk_rstn       = clk_rstn_q;
    assign busy           = busy_q;
    assign fault          = fault_q;
    assign active_profile = prof_q;
    assign retry_cnt      = (int'(retry_q) > 3) ? 2'd3 : retry_q[1:0];
endmodule
